// File: rtl/cpr_meas_sequencer.sv
// CPR ring measurement sequencer: powers one ring at a time, lets it settle,
// counts divided-ring rising edges over a window and reports each count.
// Ports: CLK/RN clock and async active-low reset; START, CH_MASK, WINDOW,
//   DIVSPEED_CFG, DIVRC_CFG sweep request (sampled in IDLE);
//   LOGICCPR_1..4 divided ring outputs; PD_1..4, CPR_RN, DIVSPEED0/1,
//   DIVRC0/1 ring control; BUSY, DONE sweep status;
//   RES_VALID/RES_READY/RES_CH/RES_COUNT per-channel result handshake.

module cpr_meas_sequencer #(
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [3:0]       CH_MASK,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic [1:0]       DIVSPEED_CFG,
    input  logic [1:0]       DIVRC_CFG,
    input  logic             LOGICCPR_1,
    input  logic             LOGICCPR_2,
    input  logic             LOGICCPR_3,
    input  logic             LOGICCPR_4,
    input  logic             RES_READY,
    output logic             PD_1,
    output logic             PD_2,
    output logic             PD_3,
    output logic             PD_4,
    output logic             CPR_RN,
    output logic             DIVSPEED0,
    output logic             DIVSPEED1,
    output logic             DIVRC0,
    output logic             DIVRC1,
    output logic             BUSY,
    output logic             DONE,
    output logic             RES_VALID,
    output logic [1:0]       RES_CH,
    output logic [CNT_W-1:0] RES_COUNT
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]       mask;
    logic [3:0]       mask_rem;
    logic [1:0]       ch;
    logic [WIN_W-1:0] win_last;
    logic [1:0]       div_speed;
    logic [1:0]       div_rc;
    logic [TMR_W-1:0] tmr;
    logic [2:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             load;
    logic             accept;
    logic             done_nxt;
    logic             tmr_last;
    logic [3:0]       ring;
    logic             ring_sel;
    logic             edge_seen;
    logic             active;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        if (m[2]) return 2'd2;
        return 2'd3;
    endfunction

    assign ring      = {LOGICCPR_4, LOGICCPR_3, LOGICCPR_2, LOGICCPR_1};
    assign ring_sel  = ring[ch];
    // sync[1] is the synchronised level, sync[2] its previous value
    assign edge_seen = sync[1] & ~sync[2];
    assign mask_rem  = mask & ~(4'b0001 << ch);
    assign accept    = (state == REPORT) && RES_READY;
    assign tmr_last  =
        ((state == SETTLE)  && (tmr == SET_LAST)) ||
        ((state == MEASURE) && (tmr == TMR_W'(win_last)));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    if (CH_MASK != 4'b0000) begin
                        load      = 1'b1;
                        state_nxt = SETTLE;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (tmr_last) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (tmr_last) state_nxt = REPORT;
            end
            REPORT: begin
                if (RES_READY) begin
                    if (mask_rem != 4'b0000) begin
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            mask      <= '0;
            ch        <= '0;
            win_last  <= '0;
            div_speed <= '0;
            div_rc    <= '0;
            tmr       <= '0;
            sync      <= '0;
            cnt       <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;

            if (load) begin
                mask      <= CH_MASK;
                ch        <= lowest(CH_MASK);
                // window of 0 behaves as a single cycle
                win_last  <= (WINDOW == '0) ? '0 : WINDOW - WIN_W'(1);
                div_speed <= DIVSPEED_CFG;
                div_rc    <= DIVRC_CFG;
            end else if (accept) begin
                mask <= mask_rem;
                if (mask_rem != 4'b0000) ch <= lowest(mask_rem);
            end

            if (tmr_last || state == IDLE || state == REPORT)
                tmr <= '0;
            else
                tmr <= tmr + TMR_W'(1);

            if (state == MEASURE)
                sync <= {sync[1:0], ring_sel};
            else
                sync <= '0;

            if (state == SETTLE)
                cnt <= '0;
            else if (state == MEASURE && edge_seen && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign active    = (state == SETTLE) || (state == MEASURE);
    assign PD_1      = !(active && ch == 2'd0);
    assign PD_2      = !(active && ch == 2'd1);
    assign PD_3      = !(active && ch == 2'd2);
    assign PD_4      = !(active && ch == 2'd3);
    assign CPR_RN    = (state == MEASURE);
    assign BUSY      = (state != IDLE);
    assign RES_VALID = (state == REPORT);
    assign DONE      = done;
    assign RES_CH    = ch;
    assign RES_COUNT = cnt;
    assign DIVSPEED0 = div_speed[0];
    assign DIVSPEED1 = div_speed[1];
    assign DIVRC0    = div_rc[0];
    assign DIVRC1    = div_rc[1];

endmodule

// File: tb/tb_cpr_meas_sequencer.sv
// Self-checking bench for cpr_meas_sequencer: sweep-level reference model
// compared every cycle, plus directed literal expectations and random sweeps.

module tb_cpr_meas_sequencer;

    localparam int SC = 16;
    localparam int CW = 8;
    localparam int WW = 12;

    logic          CLK = 1'b0;
    logic          RN = 1'b0;
    logic          START = 1'b0;
    logic [3:0]    CH_MASK = '0;
    logic [WW-1:0] WINDOW = '0;
    logic [1:0]    DIVSPEED_CFG = '0;
    logic [1:0]    DIVRC_CFG = '0;
    logic [3:0]    lcpr = '0;
    logic          RES_READY = 1'b1;
    logic          PD_1, PD_2, PD_3, PD_4;
    logic          CPR_RN;
    logic          DIVSPEED0, DIVSPEED1, DIVRC0, DIVRC1;
    logic          BUSY, DONE, RES_VALID;
    logic [1:0]    RES_CH;
    logic [CW-1:0] RES_COUNT;

    cpr_meas_sequencer #(
        .SETTLE_CYC(SC),
        .CNT_W(CW),
        .WIN_W(WW)
    ) dut (
        .CLK(CLK),
        .RN(RN),
        .START(START),
        .CH_MASK(CH_MASK),
        .WINDOW(WINDOW),
        .DIVSPEED_CFG(DIVSPEED_CFG),
        .DIVRC_CFG(DIVRC_CFG),
        .LOGICCPR_1(lcpr[0]),
        .LOGICCPR_2(lcpr[1]),
        .LOGICCPR_3(lcpr[2]),
        .LOGICCPR_4(lcpr[3]),
        .RES_READY(RES_READY),
        .PD_1(PD_1),
        .PD_2(PD_2),
        .PD_3(PD_3),
        .PD_4(PD_4),
        .CPR_RN(CPR_RN),
        .DIVSPEED0(DIVSPEED0),
        .DIVSPEED1(DIVSPEED1),
        .DIVRC0(DIVRC0),
        .DIVRC1(DIVRC1),
        .BUSY(BUSY),
        .DONE(DONE),
        .RES_VALID(RES_VALID),
        .RES_CH(RES_CH),
        .RES_COUNT(RES_COUNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 settle, 2 measure, 3 report
    int         m_phase = 0;
    int         m_left = 0;
    int         m_win = 1;
    int         m_cnt = 0;
    logic [3:0] m_mask = '0;
    logic [1:0] m_ch = '0;
    logic [1:0] m_ds = '0;
    logic [1:0] m_dr = '0;
    logic       m_done = 1'b0;
    bit         xs[$];

    int per[4] = '{10, 4, 5, 8};
    int ph[4]  = '{3, 1, 0, 2};

    int got_ch[$];
    int got_cnt[$];
    int pd1_low = 0;
    int both_low = 0;
    int rn_hi = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t",
                         nm, act, req, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Rising edges seen through the synchroniser: the level starts at 0 and
    // the last two samples of the window never reach the counter.
    function automatic int count_edges();
        int n = 0;
        int lim = CW < 31 ? (1 << CW) - 1 : 32'h7fffffff;
        for (int m = 0; m < int'(xs.size()) - 2; m++)
            if (xs[m] && (m == 0 || !xs[m-1])) n++;
        return (n > lim) ? lim : n;
    endfunction

    task automatic model();
        forever begin
            @(posedge CLK or negedge RN);
            if (!RN) begin
                m_phase = 0; m_left = 0; m_mask = '0; m_ch = '0;
                m_ds = '0; m_dr = '0; m_done = 1'b0; m_cnt = 0;
            end else begin
                m_done = 1'b0;
                case (m_phase)
                    0: if (START) begin
                        if (CH_MASK != 0) begin
                            m_mask = CH_MASK;
                            m_ch = 2'(lowest(CH_MASK));
                            m_win = (WINDOW == 0) ? 1 : int'(WINDOW);
                            m_ds = DIVSPEED_CFG;
                            m_dr = DIVRC_CFG;
                            m_phase = 1;
                            m_left = SC;
                        end else begin
                            m_done = 1'b1;
                        end
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 2;
                            m_left = m_win;
                            xs.delete();
                        end
                    end
                    2: begin
                        xs.push_back(lcpr[m_ch]);
                        m_left--;
                        if (m_left == 0) begin
                            m_cnt = count_edges();
                            m_phase = 3;
                        end
                    end
                    default: if (RES_READY) begin
                        m_mask[m_ch] = 1'b0;
                        if (m_mask != 0) begin
                            m_ch = 2'(lowest(m_mask));
                            m_phase = 1;
                            m_left = SC;
                        end else begin
                            m_phase = 0;
                            m_done = 1'b1;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic rings();
        int k = 0;
        forever begin
            @(negedge CLK);
            k++;
            for (int i = 0; i < 4; i++)
                lcpr[i] = (per[i] == 0) ? 1'($urandom) :
                          (((k + ph[i]) % per[i]) < per[i] / 2);
        end
    endtask

    task automatic monitor();
        logic [3:0] exp_pd;
        forever begin
            @(negedge CLK);
            exp_pd = 4'hF;
            if (m_phase == 1 || m_phase == 2) exp_pd[m_ch] = 1'b0;
            chk("pd", {PD_4, PD_3, PD_2, PD_1}, exp_pd);
            chk("cpr_rn", CPR_RN, m_phase == 2);
            chk("busy", BUSY, m_phase != 0);
            chk("done", DONE, m_done);
            chk("res_valid", RES_VALID, m_phase == 3);
            chk("div", {DIVRC1, DIVRC0, DIVSPEED1, DIVSPEED0},
                {m_dr, m_ds});
            if (m_phase == 3) begin
                chk("res_ch", RES_CH, m_ch);
                chk("res_count", RES_COUNT, m_cnt);
            end
            pd1_low  += int'(!PD_1);
            both_low += int'(!PD_2 && !PD_4);
            rn_hi    += int'(CPR_RN);
            if (RES_VALID && RES_READY) begin
                got_ch.push_back(RES_CH);
                got_cnt.push_back(RES_COUNT);
            end
        end
    endtask

    task automatic start_sweep(input logic [3:0] m, input int w,
                               input logic [1:0] ds, input logic [1:0] dr);
        @(posedge CLK); #2;
        START = 1'b1;
        CH_MASK = m;
        WINDOW = WW'(w);
        DIVSPEED_CFG = ds;
        DIVRC_CFG = dr;
        @(posedge CLK); #2;
        START = 1'b0;
        CH_MASK = 4'($urandom);
        WINDOW = WW'($urandom);
        DIVSPEED_CFG = 2'($urandom);
        DIVRC_CFG = 2'($urandom);
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge CLK); #2;
            if (DONE) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, seen, 1'b1);
    endtask

    function automatic bit in_rng(input int v, input int lo, input int hi);
        return v >= lo && v <= hi;
    endfunction

    initial begin
        int b, s0, s1;
        bit seen;
        fork
            model();
            rings();
            monitor();
        join_none

        // reset state
        #12;
        chk("rst_pd", {PD_4, PD_3, PD_2, PD_1}, 4'hF);
        chk("rst_cpr_rn", CPR_RN, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_valid", RES_VALID, 1'b0);
        chk("rst_res", {RES_CH, RES_COUNT}, '0);
        chk("rst_div", {DIVRC1, DIVRC0, DIVSPEED1, DIVSPEED0}, 4'h0);
        @(posedge CLK); #2;
        RN = 1'b1;

        // single ring, period 10, window 1000
        b = got_cnt.size(); s0 = pd1_low; s1 = rn_hi;
        start_sweep(4'b0001, 1000, 2'b10, 2'b01);
        wait_done(1200, "t1_done");
        chk("t1_nres", got_cnt.size() - b, 1);
        chk("t1_ch", got_ch[b], 0);
        chk("t1_cnt", in_rng(got_cnt[b], 99, 101), 1'b1);
        chk("t1_pd1_low", pd1_low - s0, SC + 1000);
        chk("t1_meas_cyc", rn_hi - s1, 1000);
        chk("t1_divspeed", {DIVSPEED1, DIVSPEED0}, 2'b10);

        // rings 2 and 4, periods 4 and 8
        b = got_cnt.size(); s0 = both_low;
        start_sweep(4'b1010, 200, 2'b01, 2'b11);
        wait_done(600, "t2_done");
        chk("t2_nres", got_cnt.size() - b, 2);
        chk("t2_ch0", got_ch[b], 1);
        chk("t2_cnt0", in_rng(got_cnt[b], 49, 51), 1'b1);
        chk("t2_ch1", got_ch[b+1], 3);
        chk("t2_cnt1", in_rng(got_cnt[b+1], 24, 26), 1'b1);
        chk("t2_pd_overlap", both_low - s0, 0);
        chk("t2_divrc", {DIVRC1, DIVRC0}, 2'b11);

        // back-pressure on ring 3
        b = got_cnt.size();
        RES_READY = 1'b0;
        start_sweep(4'b0100, 20, 2'b00, 2'b10);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK); #2;
            if (RES_VALID) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_valid", seen, 1'b1);
        repeat (25) @(posedge CLK);
        #2;
        chk("bp_pd", {PD_4, PD_3, PD_2, PD_1}, 4'hF);
        chk("bp_cpr_rn", CPR_RN, 1'b0);
        repeat (25) @(posedge CLK);
        #2;
        chk("bp_hold", RES_VALID, 1'b1);
        RES_READY = 1'b1;
        wait_done(1, "bp_resume");
        chk("bp_cnt", in_rng(got_cnt[b], 3, 5), 1'b1);

        // empty mask
        b = got_cnt.size();
        start_sweep(4'b0000, 50, 2'b11, 2'b11);
        chk("zm_done", DONE, 1'b1);
        chk("zm_busy", BUSY, 1'b0);
        @(posedge CLK); #2;
        chk("zm_done_pulse", DONE, 1'b0);
        chk("zm_nres", got_cnt.size() - b, 0);

        // zero window: one measurement cycle
        b = got_cnt.size(); s1 = rn_hi;
        start_sweep(4'b0001, 0, 2'b01, 2'b00);
        wait_done(100, "w0_done");
        chk("w0_meas_cyc", rn_hi - s1, 1);
        chk("w0_cnt", got_cnt[b], 0);

        // saturation
        b = got_cnt.size();
        per[0] = 3; ph[0] = 0;
        start_sweep(4'b0001, 1000, 2'b00, 2'b00);
        wait_done(1200, "sat_done");
        chk("sat_cnt", got_cnt[b], (1 << CW) - 1);

        // reset during measurement of ring 2
        b = got_cnt.size();
        per[1] = 6;
        start_sweep(4'b0010, 300, 2'b11, 2'b01);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK); #2;
            if (CPR_RN) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rr_measure", seen, 1'b1);
        repeat (20) @(posedge CLK);
        #3;
        RN = 1'b0;
        #1;
        chk("rr_pd", {PD_4, PD_3, PD_2, PD_1}, 4'hF);
        chk("rr_cpr_rn", CPR_RN, 1'b0);
        chk("rr_busy", BUSY, 1'b0);
        chk("rr_valid", RES_VALID, 1'b0);
        chk("rr_done", DONE, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        RN = 1'b1;
        chk("rr_nres", got_cnt.size() - b, 0);
        start_sweep(4'b0010, 30, 2'b10, 2'b10);
        wait_done(200, "rr_again");
        chk("rr_ch", got_ch[b], 1);
        chk("rr_cnt", in_rng(got_cnt[b], 4, 6), 1'b1);

        // random sweeps with noise on START and config inputs
        for (int it = 0; it < 15; it++) begin
            for (int i = 0; i < 4; i++) begin
                per[i] = ($urandom_range(0, 2) == 0) ? 0 :
                         int'($urandom_range(2, 9));
                ph[i] = int'($urandom_range(0, 9));
            end
            RES_READY = 1'($urandom_range(0, 1));
            start_sweep(4'($urandom_range(1, 15)),
                        int'($urandom_range(0, 40)),
                        2'($urandom), 2'($urandom));
            seen = 1'b0;
            for (int n = 0; n < 1500; n++) begin
                @(posedge CLK); #2;
                if (DONE) begin
                    seen = 1'b1;
                    break;
                end
                RES_READY = ($urandom_range(0, 3) != 0);
                START = ($urandom_range(0, 7) == 0);
                CH_MASK = 4'($urandom);
                WINDOW = WW'($urandom);
                DIVSPEED_CFG = 2'($urandom);
                DIVRC_CFG = 2'($urandom);
            end
            START = 1'b0;
            chk("rand_done", seen, 1'b1);
        end

        repeat (4) @(posedge CLK);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
